// File: rtl/ctrl_writeback_seq_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle write-back sequencer.
//   state_t   : S_INIT..S_TRAP, 3-bit FSM state (also exported on state_o)
//   iclass_t  : decoded instruction class for the supported subset
//   ctrl_t    : bundle of per-cycle control outputs
//   OP_* / F_*: opcode and funct constants
//   RW_* / WD_*: BancoWriteReg and WDataSel select codes
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      I_BAD, I_RALU, I_JR, I_ADDI, I_LW, I_SW, I_JAL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_JR  = 6'h08;

   // RW_RS is reserved: encoded for the mux but never produced here.
   localparam logic [2:0] RW_RT = 3'd0;
   localparam logic [2:0] RW_RD = 3'd1;
   localparam logic [2:0] RW_RS = 3'd2;
   localparam logic [2:0] RW_SP = 3'd3;
   localparam logic [2:0] RW_RA = 3'd4;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MDR = 2'd1;
   localparam logic [1:0] WD_PC  = 2'd2;
   localparam logic [1:0] WD_SP  = 2'd3;

   typedef struct packed {
      logic [2:0] wsel;
      logic       reg_write;
      logic [1:0] wdsel;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
   } ctrl_t;

   function automatic iclass_t decode(input logic [5:0] op, input logic [5:0] fn);
      iclass_t c;
      c = I_BAD;
      case (op)
         OP_RTYPE: begin
            case (fn)
               F_ADD, F_SUB, F_AND: c = I_RALU;
               F_JR:                c = I_JR;
               default:             c = I_BAD;
            endcase
         end
         OP_ADDI: c = I_ADDI;
         OP_LW:   c = I_LW;
         OP_SW:   c = I_SW;
         OP_JAL:  c = I_JAL;
         default: c = I_BAD;
      endcase
      return c;
   endfunction

   // Instructions whose ALU result can overflow (and is trapped when enabled).
   function automatic logic ovf_op(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_ADDI) || ((op == OP_RTYPE) && ((fn == F_ADD) || (fn == F_SUB)));
   endfunction

endpackage

// File: rtl/ctrl_writeback_seq_if.sv
// ctrl_writeback_seq_if: IR/ALU/memory status in, register-bank and memory
// controls out.
//   master : the sequencer (consumes opcode/funct/overflow/mem_ready)
//   slave  : the datapath side (drives status, consumes controls)
interface ctrl_writeback_seq_if;
   import cpu_ctrl_pkg::*;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       overflow;
   logic       mem_ready;
   logic [2:0] BancoWriteReg;
   logic       RegWrite;
   logic [1:0] WDataSel;
   logic [7:0] sp_init_val;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       PCWrite;
   logic       err;
   logic [2:0] state_o;

   modport master (
      input  opcode, funct, overflow, mem_ready,
      output BancoWriteReg, RegWrite, WDataSel, sp_init_val,
             MemRead, MemWrite, IRWrite, PCWrite, err, state_o
   );

   modport slave (
      output opcode, funct, overflow, mem_ready,
      input  BancoWriteReg, RegWrite, WDataSel, sp_init_val,
             MemRead, MemWrite, IRWrite, PCWrite, err, state_o
   );
endinterface

// File: rtl/ctrl_writeback_seq_timer.sv
// mem_wait_timer: counts cycles spent waiting on memory.
//   clk, reset : clock, synchronous active-high reset
//   en         : a memory wait is in progress this cycle
//   clr        : restart the count (access done or timed out)
//   tmo        : this is the LIMIT-th waiting cycle
module mem_wait_timer #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tmo
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   assign tmo = en && (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset || clr || !en) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/ctrl_writeback_seq.sv
// ctrl_writeback_seq: multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// for the register-bank write path (add/sub/and/jr, addi, lw, sw, jal).
//   clk, reset : clock, synchronous active-high reset
//   bus        : ctrl_writeback_seq_if.master (status in, controls out)
// Build option: OVERFLOW_TRAP_EN routes overflowing add/sub/addi to S_TRAP.
module ctrl_writeback_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int SP_INIT     = 227
) (
   input  logic                 clk,
   input  logic                 reset,
   ctrl_writeback_seq_if.master bus
);
   state_t  st, nxt;
   iclass_t cls;
   ctrl_t   ctl;
   logic    err_q, set_err, tmr_en, tmr_clr, tmo;

   // IR only loads in FETCH, so opcode/funct are stable for the whole instruction.
   assign cls = decode(bus.opcode, bus.funct);

   mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_tmr (
      .clk   (clk),
      .reset (reset),
      .en    (tmr_en),
      .clr   (tmr_clr),
      .tmo   (tmo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st    <= S_INIT;
         err_q <= 1'b0;
      end else begin
         st <= nxt;
         if (set_err) err_q <= 1'b1;
      end
   end

   always_comb begin
      nxt     = st;
      ctl     = '0;
      tmr_en  = 1'b0;
      tmr_clr = 1'b0;
      set_err = 1'b0;
      case (st)
         S_INIT: begin
            ctl.wsel      = RW_SP;
            ctl.wdsel     = WD_SP;
            ctl.reg_write = 1'b1;
            nxt           = S_FETCH;
         end
         S_FETCH: begin
            ctl.mem_read = 1'b1;
            tmr_en       = 1'b1;
            if (bus.mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
               tmr_clr      = 1'b1;
               nxt          = S_DECODE;
            end else if (tmo) begin
               set_err = 1'b1;
               tmr_clr = 1'b1;
            end
         end
         S_DECODE: nxt = (cls == I_BAD) ? S_FETCH : S_EXEC;
         S_EXEC: begin
            case (cls)
               I_RALU, I_ADDI: begin
                  nxt = S_WB;
`ifdef OVERFLOW_TRAP_EN
                  if (bus.overflow && ovf_op(bus.opcode, bus.funct)) nxt = S_TRAP;
`endif
               end
               I_LW, I_SW: nxt = S_MEM;
               I_JAL: begin
                  ctl.wsel      = RW_RA;
                  ctl.wdsel     = WD_PC;
                  ctl.reg_write = 1'b1;
                  ctl.pc_write  = 1'b1;
                  nxt           = S_FETCH;
               end
               I_JR: begin
                  ctl.pc_write = 1'b1;
                  nxt          = S_FETCH;
               end
               default: nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            ctl.mem_read  = (cls == I_LW);
            ctl.mem_write = (cls == I_SW);
            tmr_en        = 1'b1;
            if (bus.mem_ready) begin
               tmr_clr = 1'b1;
               nxt     = (cls == I_LW) ? S_WB : S_FETCH;
            end else if (tmo) begin
               // Abandon the access; no write-back for a timed-out load.
               set_err = 1'b1;
               tmr_clr = 1'b1;
               nxt     = S_FETCH;
            end
         end
         S_WB: begin
            ctl.reg_write = 1'b1;
            ctl.wsel      = (cls == I_RALU) ? RW_RD : RW_RT;
            ctl.wdsel     = (cls == I_LW) ? WD_MDR : WD_ALU;
            nxt           = S_FETCH;
         end
`ifdef OVERFLOW_TRAP_EN
         S_TRAP: begin
            ctl.wsel      = RW_RA;
            ctl.wdsel     = WD_PC;
            ctl.reg_write = 1'b1;
            ctl.pc_write  = 1'b1;
            set_err       = 1'b1;
            nxt           = S_FETCH;
         end
`endif
         default: nxt = S_FETCH;
      endcase
      // Reset aborts in the same cycle: suppress any write from the old state.
      if (reset) ctl = '0;
   end

   assign bus.BancoWriteReg = ctl.wsel;
   assign bus.RegWrite      = ctl.reg_write;
   assign bus.WDataSel      = ctl.wdsel;
   assign bus.MemRead       = ctl.mem_read;
   assign bus.MemWrite      = ctl.mem_write;
   assign bus.IRWrite       = ctl.ir_write;
   assign bus.PCWrite       = ctl.pc_write;
   assign bus.sp_init_val   = 8'(SP_INIT);
   assign bus.err           = err_q;
   assign bus.state_o       = st;
endmodule

// File: tb/tb_ctrl_writeback_seq.sv
// tb_ctrl_writeback_seq: directed vectors with hand-computed control words
// for ctrl_writeback_seq (default build, or OVERFLOW_TRAP_EN when defined).
module tb_ctrl_writeback_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tot = 0;
   int   n_bad = 0;
   logic exp_err;

   always #5 clk = ~clk;

   ctrl_writeback_seq_if bus();

   ctrl_writeback_seq #(.MEM_TIMEOUT(15), .SP_INIT(227)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // {state, BancoWriteReg, RegWrite, WDataSel, MemRead, MemWrite, IRWrite, PCWrite}
   logic [12:0] obs;
   assign obs = {bus.state_o, bus.BancoWriteReg, bus.RegWrite, bus.WDataSel,
                 bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite};

   function automatic logic [12:0] v(input int st, input int bw, input int rw, input int wd,
                                     input int mr, input int mw, input int ir, input int pc);
      logic [31:0] s, b, w;
      s = st; b = bw; w = wd;
      return {s[2:0], b[2:0], rw[0], w[1:0], mr[0], mw[0], ir[0], pc[0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive inputs just after the falling edge; outputs are sampled 1 ns later.
   task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input logic ovf);
      @(negedge clk);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.mem_ready = rdy;
      bus.overflow  = ovf;
      #1;
   endtask

   localparam logic [12:0] V_IDLE = 13'h0;

   initial begin
      bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1; bus.overflow = 1'b0;
      exp_err = 1'b0;

      // reset held: S_INIT, all enables low
      step(6'h00, 6'h20, 1, 0);
      chk("rst_vec", obs, v(0,0,0,0,0,0,0,0));
      chk("rst_err", bus.err, 0);

      // init cycle writes SP_INIT to $29
      @(negedge clk); reset = 1'b0; #1;
      chk("init_vec", obs, v(0,3,1,3,0,0,0,0));
      chk("sp_val", bus.sp_init_val, 227);

      // add, zero-wait: FETCH, DECODE, EXEC, WB
      step(6'h00, 6'h20, 1, 0); chk("add_fetch", obs, v(1,0,0,0,1,0,1,1));
      step(6'h00, 6'h20, 1, 0); chk("add_dec",   obs, v(2,0,0,0,0,0,0,0));
      step(6'h00, 6'h20, 1, 0); chk("add_exec",  obs, v(3,0,0,0,0,0,0,0));
      step(6'h00, 6'h20, 1, 0); chk("add_wb",    obs, v(5,1,1,0,0,0,0,0));

      // lw with 3 wait cycles in S_MEM
      step(6'h23, 6'h00, 1, 0); chk("lw_fetch", obs, v(1,0,0,0,1,0,1,1));
      step(6'h23, 6'h00, 1, 0); chk("lw_dec",   obs, v(2,0,0,0,0,0,0,0));
      step(6'h23, 6'h00, 1, 0); chk("lw_exec",  obs, v(3,0,0,0,0,0,0,0));
      for (int i = 0; i < 3; i++) begin
         step(6'h23, 6'h00, 0, 0); chk("lw_wait", obs, v(4,0,0,0,1,0,0,0));
      end
      step(6'h23, 6'h00, 1, 0); chk("lw_done", obs, v(4,0,0,0,1,0,0,0));
      step(6'h23, 6'h00, 1, 0); chk("lw_wb",   obs, v(5,0,1,1,0,0,0,0));

      // jal writes $31 in EXEC and skips WB
      step(6'h03, 6'h00, 1, 0); chk("jal_fetch", obs, v(1,0,0,0,1,0,1,1));
      step(6'h03, 6'h00, 1, 0); chk("jal_dec",   obs, v(2,0,0,0,0,0,0,0));
      step(6'h03, 6'h00, 1, 0); chk("jal_exec",  obs, v(3,4,1,2,0,0,0,1));

      // jr: PCWrite only
      step(6'h00, 6'h08, 1, 0); chk("jr_fetch", obs, v(1,0,0,0,1,0,1,1));
      step(6'h00, 6'h08, 1, 0); chk("jr_dec",   obs, v(2,0,0,0,0,0,0,0));
      step(6'h00, 6'h08, 1, 0); chk("jr_exec",  obs, v(3,0,0,0,0,0,0,1));

      // unknown opcode: DECODE straight back to FETCH
      step(6'h3F, 6'h00, 1, 0); chk("bad_fetch", obs, v(1,0,0,0,1,0,1,1));
      step(6'h3F, 6'h00, 1, 0); chk("bad_dec",   obs, v(2,0,0,0,0,0,0,0));
      step(6'h00, 6'h01, 1, 0); chk("bad_back",  obs, v(1,0,0,0,1,0,1,1));
      // R-type with unknown funct
      step(6'h00, 6'h01, 1, 0); chk("badf_dec",  obs, v(2,0,0,0,0,0,0,0));

      // addi with overflow asserted in EXEC
      step(6'h08, 6'h00, 1, 0); chk("ovf_fetch", obs, v(1,0,0,0,1,0,1,1));
      step(6'h08, 6'h00, 1, 0); chk("ovf_dec",   obs, v(2,0,0,0,0,0,0,0));
      step(6'h08, 6'h00, 1, 1); chk("ovf_exec",  obs, v(3,0,0,0,0,0,0,0));
`ifdef OVERFLOW_TRAP_EN
      step(6'h08, 6'h00, 1, 0); chk("ovf_trap",  obs, v(6,4,1,2,0,0,0,1));
      exp_err = 1'b1;
`else
      step(6'h08, 6'h00, 1, 0); chk("ovf_wb",    obs, v(5,0,1,0,0,0,0,0));
`endif
      step(6'h2B, 6'h00, 1, 0); chk("ovf_after", obs, v(1,0,0,0,1,0,1,1));
      chk("ovf_err", bus.err, exp_err);

      // sw with memory never ready: 15 wait cycles then timeout to FETCH
      step(6'h2B, 6'h00, 1, 0); chk("sw_dec",  obs, v(2,0,0,0,0,0,0,0));
      step(6'h2B, 6'h00, 1, 0); chk("sw_exec", obs, v(3,0,0,0,0,0,0,0));
      for (int i = 0; i < 15; i++) begin
         step(6'h2B, 6'h00, 0, 0);
         chk("sw_wait", obs, v(4,0,0,0,0,1,0,0));
         chk("sw_err_lo", bus.err, exp_err);
      end
      step(6'h2B, 6'h00, 0, 0); chk("sw_tmo", obs, v(1,0,0,0,1,0,0,0));
      chk("sw_err", bus.err, 1);

      // sw again, reset asserted mid-wait in S_MEM
      step(6'h2B, 6'h00, 1, 0); chk("rs_fetch", obs, v(1,0,0,0,1,0,1,1));
      step(6'h2B, 6'h00, 1, 0); chk("rs_dec",   obs, v(2,0,0,0,0,0,0,0));
      step(6'h2B, 6'h00, 1, 0); chk("rs_exec",  obs, v(3,0,0,0,0,0,0,0));
      step(6'h2B, 6'h00, 0, 0); chk("rs_mem",   obs, v(4,0,0,0,0,1,0,0));
      @(negedge clk); reset = 1'b1; #1;
      chk("rs_abort", obs, v(4,0,0,0,0,0,0,0));
      @(negedge clk); reset = 1'b0; #1;
      chk("rs_init", obs, v(0,3,1,3,0,0,0,0));
      chk("rs_err",  bus.err, 0);
      step(6'h2B, 6'h00, 1, 0); chk("rs_refetch", obs, v(1,0,0,0,1,0,1,1));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
